// File: rtl/jtgng_timing_pkg.sv
// Default 15 kHz arcade timing shared by the timing generator, scan doubler and benches.
package jtgng_timing_pkg;

  localparam int unsigned H_TOTAL  = 384;
  localparam int unsigned H_ACTIVE = 256;
  localparam int unsigned HS_START = 288;
  localparam int unsigned HS_END   = 320;
  localparam int unsigned V_TOTAL  = 262;
  localparam int unsigned V_ACTIVE = 224;
  localparam int unsigned VS_START = 232;
  localparam int unsigned VS_END   = 236;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic timing_ok(input int unsigned active, input int unsigned sync_start,
                                     input int unsigned sync_end, input int unsigned total);
    return (active < sync_start) && (sync_start < sync_end) &&
           (sync_end <= total) && (total <= 512);
  endfunction

endpackage

// File: rtl/jtgng_arc_pattern.sv
// Colour-bar test pattern: 8 bars of 32 pixels with a white border around the active area.
module jtgng_arc_pattern #(
  parameter int unsigned H_ACTIVE = jtgng_timing_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = jtgng_timing_pkg::V_ACTIVE
) (
  input  logic [8:0]  H,
  input  logic [8:0]  V,
  output logic [11:0] rgb
);

  jtgng_timing_pkg::rgb_t bar;
  logic                   border;

  always_comb begin
    // Bar index is H[7:5]; its bits map to red, green and blue respectively.
    bar.r  = {4{H[5]}};
    bar.g  = {4{H[6]}};
    bar.b  = {4{H[7]}};
    border = (H == '0) || (H == 9'(H_ACTIVE - 1)) ||
             (V == '0) || (V == 9'(V_ACTIVE - 1));
    rgb    = border ? '1 : bar;
  end

endmodule

// File: rtl/jtgng_arc_timing.sv
// Native 15 kHz video timing with registered colour output aligned to delayed blanking.
module jtgng_arc_timing #(
  parameter int unsigned H_TOTAL  = jtgng_timing_pkg::H_TOTAL,
  parameter int unsigned H_ACTIVE = jtgng_timing_pkg::H_ACTIVE,
  parameter int unsigned HS_START = jtgng_timing_pkg::HS_START,
  parameter int unsigned HS_END   = jtgng_timing_pkg::HS_END,
  parameter int unsigned V_TOTAL  = jtgng_timing_pkg::V_TOTAL,
  parameter int unsigned V_ACTIVE = jtgng_timing_pkg::V_ACTIVE,
  parameter int unsigned VS_START = jtgng_timing_pkg::VS_START,
  parameter int unsigned VS_END   = jtgng_timing_pkg::VS_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic        pattern_en,
  input  logic [11:0] rgb_in,
  output logic [8:0]  H,
  output logic [8:0]  V,
  output logic        LHBL,
  output logic        LVBL,
  output logic        HS,
  output logic        VS,
  output logic        Hinit,
  output logic        Vinit,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  if (!jtgng_timing_pkg::timing_ok(H_ACTIVE, HS_START, HS_END, H_TOTAL)) begin : g_bad_h
    $error("jtgng_arc_timing: inconsistent horizontal timing parameters");
  end
  if (!jtgng_timing_pkg::timing_ok(V_ACTIVE, VS_START, VS_END, V_TOTAL)) begin : g_bad_v
    $error("jtgng_arc_timing: inconsistent vertical timing parameters");
  end

  logic [8:0]  h_q, h_d, v_q, v_d, h_nx, v_nx;
  logic        lhbl_q, lhbl_d, lvbl_q, lvbl_d, hs_q, hs_d, vs_q, vs_d;
  logic        hinit_q, hinit_d, vinit_q, vinit_d;
  logic [11:0] rgb_q, rgb_d, pat_rgb, src_rgb;
  logic        lhbl_dly_q, lhbl_dly_d, lvbl_dly_q, lvbl_dly_d;
  logic        h_wrap, v_wrap;

  jtgng_arc_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .H   (h_q),
    .V   (v_q),
    .rgb (pat_rgb)
  );

  always_comb begin
    h_wrap     = (h_q == 9'(H_TOTAL - 1));
    v_wrap     = (v_q == 9'(V_TOTAL - 1));
    h_nx       = h_wrap ? '0 : h_q + 9'd1;
    v_nx       = h_wrap ? (v_wrap ? '0 : v_q + 9'd1) : v_q;
    src_rgb    = pattern_en ? pat_rgb : rgb_in;
    h_d        = h_q;
    v_d        = v_q;
    lhbl_d     = lhbl_q;
    lvbl_d     = lvbl_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    hinit_d    = 1'b0;
    vinit_d    = 1'b0;
    rgb_d      = rgb_q;
    lhbl_dly_d = lhbl_dly_q;
    lvbl_dly_d = lvbl_dly_q;
    if (cen6) begin
      h_d        = h_nx;
      v_d        = v_nx;
      // Flags come from the next counts so they land together with H/V.
      lhbl_d     = {1'b0, h_nx} < 10'(H_ACTIVE);
      hs_d       = !(({1'b0, h_nx} >= 10'(HS_START)) && ({1'b0, h_nx} < 10'(HS_END)));
      lvbl_d     = {1'b0, v_nx} < 10'(V_ACTIVE);
      vs_d       = !(({1'b0, v_nx} >= 10'(VS_START)) && ({1'b0, v_nx} < 10'(VS_END)));
      hinit_d    = h_wrap;
      vinit_d    = h_wrap && v_wrap;
      rgb_d      = (lhbl_q && lvbl_q) ? src_rgb : '0;
      lhbl_dly_d = lhbl_q;
      lvbl_dly_d = lvbl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      lhbl_q     <= 1'b1;
      lvbl_q     <= 1'b1;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      hinit_q    <= 1'b0;
      vinit_q    <= 1'b0;
      rgb_q      <= '0;
      lhbl_dly_q <= 1'b1;
      lvbl_dly_q <= 1'b1;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      lhbl_q     <= lhbl_d;
      lvbl_q     <= lvbl_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hinit_q    <= hinit_d;
      vinit_q    <= vinit_d;
      rgb_q      <= rgb_d;
      lhbl_dly_q <= lhbl_dly_d;
      lvbl_dly_q <= lvbl_dly_d;
    end
  end

  always_comb begin
    H        = h_q;
    V        = v_q;
    LHBL     = lhbl_q;
    LVBL     = lvbl_q;
    HS       = hs_q;
    VS       = vs_q;
    Hinit    = hinit_q;
    Vinit    = vinit_q;
    red      = rgb_q[11:8];
    green    = rgb_q[7:4];
    blue     = rgb_q[3:0];
    LHBL_dly = lhbl_dly_q;
    LVBL_dly = lvbl_dly_q;
  end

endmodule

// File: tb/tb_jtgng_arc_timing.sv
// Bench for jtgng_arc_timing: pixel-count reference model plus directed line/frame/reset checks.
module tb_jtgng_arc_timing;

  // Default horizontal timing; a short frame keeps full-frame coverage within the cycle budget.
  localparam int unsigned HT  = 384;
  localparam int unsigned HA  = 256;
  localparam int unsigned HSS = 288;
  localparam int unsigned HSE = 320;
  localparam int unsigned VT  = 16;
  localparam int unsigned VA  = 12;
  localparam int unsigned VSS = 13;
  localparam int unsigned VSE = 15;

  logic        clk = 1'b0;
  logic        rst, cen6, pattern_en;
  logic [11:0] rgb_in;
  logic [8:0]  H, V;
  logic        LHBL, LVBL, HS, VS, Hinit, Vinit, LHBL_dly, LVBL_dly;
  logic [3:0]  red, green, blue;

  jtgng_arc_timing #(
    .H_TOTAL (HT), .H_ACTIVE (HA), .HS_START (HSS), .HS_END (HSE),
    .V_TOTAL (VT), .V_ACTIVE (VA), .VS_START (VSS), .VS_END (VSE)
  ) u_dut (
    .clk (clk), .rst (rst), .cen6 (cen6), .pattern_en (pattern_en), .rgb_in (rgb_in),
    .H (H), .V (V), .LHBL (LHBL), .LVBL (LVBL), .HS (HS), .VS (VS),
    .Hinit (Hinit), .Vinit (Vinit), .red (red), .green (green), .blue (blue),
    .LHBL_dly (LHBL_dly), .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, errors = 0;
  // Model state: n = number of pixel enables since reset.
  int unsigned n = 0;
  bit          m_hinit = 0, m_vinit = 0, m_hd = 1, m_vd = 1;
  logic [11:0] m_col = '0;
  logic [11:0] line_cap [0:383];
  int unsigned cnt_hinit, cnt_vinit, hs_low_px, vs_lines, lvbl_lines, vs_stray, hmax;
  logic        prev_vs = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int unsigned h, input int unsigned v,
                                            input bit pe, input logic [11:0] ext);
    int unsigned bar;
    if (!pe) return ext;
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 12'hFFF;
    bar = (h / 32) % 8;
    return {((bar % 2) != 0) ? 4'hF : 4'h0,
            (((bar / 2) % 2) != 0) ? 4'hF : 4'h0,
            (((bar / 4) % 2) != 0) ? 4'hF : 4'h0};
  endfunction

  task automatic model_reset();
    n = 0; m_hinit = 0; m_vinit = 0; m_col = '0; m_hd = 1; m_vd = 1; prev_vs = 1'b1;
  endtask

  task automatic check_reset_state();
    chk("rst_H", H, 0);
    chk("rst_V", V, 0);
    chk("rst_flags", {LHBL, LVBL, HS, VS}, 4'hF);
    chk("rst_inits", {Hinit, Vinit}, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_dly", {LHBL_dly, LVBL_dly}, 2'b11);
  endtask

  task automatic tick();
    int unsigned ph, pv, h, v;
    ph = 0;
    @(posedge clk);
    if (cen6) begin
      ph = n % HT;
      pv = (n / HT) % VT;
      m_col   = (ph < HA && pv < VA) ? ref_pixel(ph, pv, pattern_en, rgb_in) : 12'h000;
      m_hd    = ph < HA;
      m_vd    = pv < VA;
      n++;
      m_hinit = (n % HT) == 0;
      m_vinit = m_hinit && ((n / HT) % VT) == 0;
    end else begin
      m_hinit = 0;
      m_vinit = 0;
    end
    #1;
    h = n % HT;
    v = (n / HT) % VT;
    chk("H", H, h);
    chk("V", V, v);
    chk("flags", {LHBL, LVBL, HS, VS},
        {h < HA, v < VA, !(h >= HSS && h < HSE), !(v >= VSS && v < VSE)});
    chk("inits", {Hinit, Vinit}, {m_hinit, m_vinit});
    chk("rgb", {red, green, blue}, m_col);
    chk("dly", {LHBL_dly, LVBL_dly}, {m_hd, m_vd});
    if (cen6) line_cap[ph] = {red, green, blue};
    cnt_hinit += Hinit;
    cnt_vinit += Vinit;
    if (cen6 && !HS) hs_low_px++;
    if (Hinit && !VS) vs_lines++;
    if (Hinit && !LVBL) lvbl_lines++;
    if (VS !== prev_vs && !Hinit) vs_stray++;
    prev_vs = VS;
    if (H > hmax) hmax = H;
  endtask

  task automatic clear_counts();
    cnt_hinit = 0; cnt_vinit = 0; hs_low_px = 0; vs_lines = 0;
    lvbl_lines = 0; vs_stray = 0; hmax = 0;
  endtask

  initial begin
    int unsigned guard, cv;
    bit l10_done, l11_done;
    rst = 1'b1; cen6 = 1'b0; pattern_en = 1'b0; rgb_in = '0;
    l10_done = 0; l11_done = 0;
    clear_counts();
    #2;
    check_reset_state();
    #10 rst = 1'b0;
    model_reset();

    // First line at the nominal one-in-four pixel rate.
    for (int i = 0; i < 1536; i++) begin
      cen6   = (i % 4) == 0;
      rgb_in = 12'($urandom);
      tick();
      if (i == 0) chk("first_cen_H", H, 1);
    end
    chk("line0_hinit_count", cnt_hinit, 1);
    chk("line0_hmax", hmax, HT - 1);
    chk("line0_end_H", H, 0);
    chk("line0_end_V", V, 1);

    // Rest of the frame with random enables, sources and pixels.
    clear_counts();
    guard = 0;
    while (n < HT * VT && guard < 200000) begin
      cv         = (n / HT) % VT;
      cen6       = $urandom_range(0, 3) == 0;
      pattern_en = (cv == 10) ? 1'b1 : (cv == 11) ? 1'b0 : 1'($urandom_range(0, 1));
      rgb_in     = (cv == 11) ? 12'h5A3 : 12'($urandom);
      tick();
      guard++;
      if (!l10_done && n == 11 * HT) begin
        l10_done = 1;
        chk("bar_h40", line_cap[40], 12'hF00);
        chk("border_h0", line_cap[0], 12'hFFF);
        chk("white_h250", line_cap[250], 12'hFFF);
        chk("yellow_h100", line_cap[100], 12'hFF0);
        chk("pat_blank_h300", line_cap[300], 12'h000);
      end
      if (!l11_done && n == 12 * HT) begin
        l11_done = 1;
        chk("pass_h0", line_cap[0], 12'h5A3);
        chk("pass_h255", line_cap[255], 12'h5A3);
        chk("pass_blank_h256", line_cap[256], 12'h000);
        chk("pass_blank_h383", line_cap[383], 12'h000);
      end
    end
    chk("frame_reached", n == HT * VT, 1);
    chk("frame_hs_low_px", hs_low_px, (VT - 1) * (HSE - HSS));
    chk("frame_vs_lines", vs_lines, VSE - VSS);
    chk("frame_lvbl_lines", lvbl_lines, VT - VA);
    chk("frame_vinit_count", cnt_vinit, 1);
    chk("frame_hinit_count", cnt_hinit, VT - 1);
    chk("vs_edge_off_hinit", vs_stray, 0);

    // Run into the next frame, then reset mid-line.
    guard = 0;
    while ((n % (HT * VT)) != 5 * HT + 150 && guard < 100000) begin
      cen6       = $urandom_range(0, 3) == 0;
      pattern_en = 1'($urandom_range(0, 1));
      rgb_in     = 12'($urandom);
      tick();
      guard++;
    end
    chk("midline_reached", (n % (HT * VT)) == 5 * HT + 150, 1);
    #2 rst = 1'b1;
    #1 check_reset_state();
    #2 rst = 1'b0;
    model_reset();
    cen6 = 1'b1;
    tick();
    chk("restart_H", H, 1);
    for (int i = 0; i < 800; i++) begin
      cen6       = $urandom_range(0, 3) == 0;
      pattern_en = 1'($urandom_range(0, 1));
      rgb_in     = 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
